logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Two-requester controller that shares a single 32-bit AND/OR logic unit between independent clients. Runs request/grant arbitration with round-robin fairness, latches the winner's operands and operation select, and computes the result through the shared unit. Returns a registered result with a per-requester completion pulse. Sits between client blocks and the bitwise datapath, so only one AND/OR instance is needed per pair of clients.

## Interface

- WIDTH, 32, operand and result width in bits
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0 / req1  input  1  request from requester 0 / 1, level-sensitive
- op0 / op1  input  1  operation select: 0 = AND, 1 = OR
- a0 / a1  input  WIDTH  first operand of requester 0 / 1
- b0 / b1  input  WIDTH  second operand of requester 0 / 1
- gnt0 / gnt1  output  1  one-cycle grant pulse; that requester's operands were captured
- done0 / done1  output  1  one-cycle completion pulse; result is valid for that requester
- result  output  WIDTH  registered result of the most recently completed operation
- busy  output  1  high whenever state is not IDLE

## Operation

- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Samples req0 and req1.
  - If neither request is high, the block stays in IDLE.
  - If exactly one request is high, that requester wins.
  - If both are high, the winner is the requester not served last (round-robin pointer `last`).
  - On a win, the block latches the winner's op, a and b into internal registers, updates `last` to the winner, and moves to EXEC.
- **EXEC:**
  - gnt of the winner is high.
  - The latched operands drive the shared unit: op=0 computes a & b, op=1 computes a | b.
  - The unit output is registered into `result`, and the block moves to RESP.
- **RESP:**
  - done of the winner is high and `result` holds the new value.
  - The block returns to IDLE unconditionally.
- Requests are sampled only in IDLE. req, op and operands must be stable in the cycle they are sampled. Changes while busy are ignored.
- A requester that holds req high through RESP is treated as a new request at the next IDLE cycle.
- Outputs gnt0/gnt1/done0/done1 are registered and mutually exclusive. At most one of the four is high in any cycle.
- `result` holds its value between operations. It is never cleared except by reset.
- **Reset** (any state, including mid-operation): takes effect at the next rising edge.
  - State returns to IDLE and `last` is set to 1, so requester 0 wins the first tie.
  - result, gnt0, gnt1, done0, done1 and busy are all 0.
  - The latched operands are cleared.
  - An operation aborted by reset produces no done pulse.

## Timing

- Cycle T: IDLE, req sampled high. Winner's operands are captured at the end of T.
- Cycle T+1: gnt high, busy high.
- Cycle T+2: done high, result valid, busy high.
- Cycle T+3: IDLE; the next arbitration happens in this cycle.
- Latency: done is high 2 cycles after the sampling cycle. Maximum throughput is one operation per 3 cycles.
- With both requests held continuously, grants alternate 0,1,0,1,… and the first grant goes to requester 0.
- busy is low exactly in IDLE cycles, including the first cycle after reset is released.

## Test plan

- **Reset values:** assert reset for 2 cycles, then release. Required: result=0, gnt*=0, done*=0, busy=0, state IDLE.
- **Single AND:** req0=1, op0=0, a0=32'hA5A5, b0=32'h5A5A at cycle T, then drop req0 at T+1. Required: gnt0 high at T+1, done0 high at T+2, result=32'h0000_0000, no activity on gnt1/done1.
- **Single OR:** req1=1, op1=1, a1=32'hA5A5, b1=32'h5A5A. Required: done1 high at T+2, result=32'h0000_FFFF, and result holds that value afterwards.
- **Simultaneous tie after reset:** req0 (AND 32'hFF00FF00 & 32'h0FF00FF0) and req1 (OR of the same operands) both held high. Required:
  - gnt0 first, done0 with result=32'h0F000F00;
  - then gnt1 three cycles later, done1 with result=32'hFFF0FFF0.
- **Fairness:** hold both requests high for 12 cycles. Required: grants strictly alternate 0,1,0,1 at 3-cycle spacing. Also hold req0 alone continuously; required: a gnt0 every 3 cycles.
- **Reset mid-operation:** assert reset in the EXEC cycle. Required: no done pulse, result=0, busy=0 on the next cycle. A request issued after reset is released completes normally, and requester 0 wins the first tie.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Client-side bundle for the shared AND/OR logic unit arbiter.
// The master modport is the client side and the slave modport is the arbiter side.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic             op0;
  logic             op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit AND/OR unit between two requesters.
// Each accepted request produces a grant pulse one cycle later and a done pulse two cycles later.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  logic_unit_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             pick_s;

  function automatic logic [WIDTH-1:0] logic_op(input logic op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (op) begin
      r = a | b;
    end else begin
      r = a & b;
    end
    return r;
  endfunction

  // Winner on a tie is the requester not served last.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      pick_s = ~last_q;
    end else if (bus.req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d   = pick_s;
          last_d  = pick_s;
          op_d    = pick_s ? bus.op1 : bus.op0;
          a_d     = pick_s ? bus.a1  : bus.a0;
          b_d     = pick_s ? bus.b1  : bus.b0;
          gnt0_d  = ~pick_s;
          gnt1_d  = pick_s;
          busy_d  = 1'b1;
          state_d = EXEC;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = logic_op(op_q, a_q, b_q);
        done0_d  = ~win_q;
        done1_d  = win_q;
        busy_d   = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model that schedules grant/done by edge number.
module tb_logic_unit_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(W)) bus ();

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: an operation accepted at edge n shows gnt after edge n and done after edge n+1;
  // the next acceptance can happen at edge n+3 at the earliest.
  int         edge_n   = 0;
  int         acc_edge = -100;
  bit         acc_win  = 1'b0;
  bit         last_m   = 1'b1;
  logic [W-1:0] acc_res = '0;
  logic [W-1:0] exp_res = '0;
  int         grant_q[$];
  int         grant_edge_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit r0, input bit o0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                      input bit r1, input bit o1, input logic [W-1:0] x1, input logic [W-1:0] y1);
    bit e_g0, e_g1, e_d0, e_d1, e_busy;
    @(negedge clk);
    reset    = rst;
    bus.req0 = r0; bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
    bus.req1 = r1; bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
    @(posedge clk);
    if (rst) begin
      acc_edge = -100;
      last_m   = 1'b1;
      exp_res  = '0;
    end else begin
      if (edge_n >= acc_edge + 3 && (r0 || r1)) begin
        if (r0 && r1) acc_win = !last_m;
        else          acc_win = r1;
        last_m   = acc_win;
        acc_edge = edge_n;
        if (acc_win) acc_res = o1 ? (x1 | y1) : (x1 & y1);
        else         acc_res = o0 ? (x0 | y0) : (x0 & y0);
      end
      if (edge_n == acc_edge + 1) exp_res = acc_res;
    end
    e_g0   = (edge_n == acc_edge)     && !acc_win;
    e_g1   = (edge_n == acc_edge)     &&  acc_win;
    e_d0   = (edge_n == acc_edge + 1) && !acc_win;
    e_d1   = (edge_n == acc_edge + 1) &&  acc_win;
    e_busy = (edge_n == acc_edge) || (edge_n == acc_edge + 1);
    #1;
    check_val("gnt0",   {31'd0, bus.gnt0},  {31'd0, e_g0});
    check_val("gnt1",   {31'd0, bus.gnt1},  {31'd0, e_g1});
    check_val("done0",  {31'd0, bus.done0}, {31'd0, e_d0});
    check_val("done1",  {31'd0, bus.done1}, {31'd0, e_d1});
    check_val("busy",   {31'd0, bus.busy},  {31'd0, e_busy});
    check_val("result", bus.result, exp_res);
    if (bus.gnt0) begin grant_q.push_back(0); grant_edge_q.push_back(edge_n); end
    if (bus.gnt1) begin grant_q.push_back(1); grant_edge_q.push_back(edge_n); end
    edge_n++;
  endtask

  task automatic idle(input bit rst);
    step(rst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic both(input bit rst);
    step(rst, 1'b1, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b1, 32'hFF00FF00, 32'h0FF00FF0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.op0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.op1 = 1'b0; bus.a1 = '0; bus.b1 = '0;

    // Reset values
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check_val("rst_result", bus.result, 32'h0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Single AND from requester 0
    step(1'b0, 1'b1, 1'b0, 32'h0000A5A5, 32'h00005A5A, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("and_gnt0", {31'd0, bus.gnt0}, 32'd1);
    idle(1'b0);
    check_val("and_done0", {31'd0, bus.done0}, 32'd1);
    check_val("and_result", bus.result, 32'h00000000);
    idle(1'b0);

    // Single OR from requester 1
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000A5A5, 32'h00005A5A);
    check_val("or_gnt1", {31'd0, bus.gnt1}, 32'd1);
    idle(1'b0);
    check_val("or_done1", {31'd0, bus.done1}, 32'd1);
    check_val("or_result", bus.result, 32'h0000FFFF);
    idle(1'b0);
    idle(1'b0);
    check_val("or_hold", bus.result, 32'h0000FFFF);

    // Tie right after reset: requester 0 first, requester 1 three cycles later
    idle(1'b1);
    grant_q.delete(); grant_edge_q.delete();
    both(1'b0);
    check_val("tie_gnt0", {31'd0, bus.gnt0}, 32'd1);
    both(1'b0);
    check_val("tie_res0", bus.result, 32'h0F000F00);
    both(1'b0);
    both(1'b0);
    check_val("tie_gnt1", {31'd0, bus.gnt1}, 32'd1);
    both(1'b0);
    check_val("tie_res1", bus.result, 32'hFFF0FFF0);
    both(1'b0);

    // Fairness: both held continuously, grants alternate at 3-cycle spacing
    for (int i = 0; i < 12; i++) both(1'b0);
    check_val("fair_count", grant_q.size(), 32'd6);
    check_val("fair_first", grant_q[0], 32'd0);
    for (int i = 1; i < grant_q.size(); i++) begin
      check_val("fair_alt", grant_q[i], (i % 2 == 0) ? 32'd0 : 32'd1);
      check_val("fair_gap", grant_edge_q[i] - grant_edge_q[i-1], 32'd3);
    end

    // Requester 0 alone held continuously
    grant_q.delete(); grant_edge_q.delete();
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 1'b1, 32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("solo_count", grant_q.size(), 32'd3);
    for (int i = 1; i < grant_q.size(); i++) begin
      check_val("solo_who", grant_q[i], 32'd0);
      check_val("solo_gap", grant_edge_q[i] - grant_edge_q[i-1], 32'd3);
    end
    idle(1'b0);
    idle(1'b0);

    // Reset asserted during EXEC aborts the operation
    step(1'b0, 1'b1, 1'b1, 32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("abort_done0", {31'd0, bus.done0}, 32'd0);
    check_val("abort_result", bus.result, 32'h0);
    check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
    both(1'b0);
    check_val("abort_tie_gnt0", {31'd0, bus.gnt0}, 32'd1);
    both(1'b0);
    check_val("abort_res", bus.result, 32'h0F000F00);
    idle(1'b0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
